dport_tcm_resp: RTL and testbench
=================================

DPORT_TCM_RESP -- requirements
Module: dport_tcm_resp

Interface
REQ-001 Parameter BASE_ADDR, default 32'h80000000, byte address of word 0.
REQ-002 Parameter SIZE_WORDS, default 16384, number of 32-bit words; power of two.
REQ-003 Parameter QUEUE_DEPTH, default 4, request queue entries; power of two, at least 2.
REQ-004 Port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Ports mem_d_addr_i [31:0], mem_d_data_wr_i [31:0], mem_d_rd_i [1], mem_d_wr_i [3:0] byte enables, mem_d_req_tag_i [10:0], all inputs: request fields.
REQ-007 Ports mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i, inputs, 1 each: attribute and maintenance requests.
REQ-008 Port mem_d_accept_o, output, 1: request accepted this cycle when high.
REQ-009 Ports mem_d_ack_o [1], mem_d_error_o [1], mem_d_data_rd_o [31:0], mem_d_resp_tag_o [10:0], outputs: single-cycle response.

Function
REQ-010 Request valid = mem_d_rd_i | (mem_d_wr_i != 0) | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i; transfer occurs on valid & mem_d_accept_o.
REQ-011 mem_d_accept_o = (queue count < QUEUE_DEPTH), registered-count derived, independent of request inputs.
REQ-012 Op priority: any wr bit -> WRITE; else rd -> READ; else MAINT; mem_d_cacheable_i ignored.
REQ-013 Accepted request (op, word address, data, byte enables, tag) pushes into the in-order queue.
REQ-014 Head-processing FSM states IDLE, ISSUE: IDLE -> ISSUE when queue non-empty; ISSUE pops head, performs access, returns to IDLE if queue then empty, else stays in ISSUE.
REQ-015 Pop in cycle N yields mem_d_ack_o=1 for exactly cycle N+1 with head tag on mem_d_resp_tag_o; minimum accept-to-ack latency 2 cycles; sustained throughput 1 response/cycle.
REQ-016 Simultaneous push and pop leaves count unchanged; push ignored when full (cannot occur since accept low).
REQ-017 In range: BASE_ADDR <= addr < BASE_ADDR + 4*SIZE_WORDS; index = (addr - BASE_ADDR)[..:2]; addr[1:0] ignored.
REQ-018 READ in range: data_rd = RAM word, error 0.
REQ-019 WRITE in range: only enabled byte lanes updated; data_rd = 0, error 0; read-after-write to same word in next request returns new data.
REQ-020 MAINT: no RAM access, data_rd 0, error 0.
REQ-021 Out-of-range READ/WRITE: no RAM change, data_rd 0, error 1, ack still given.
REQ-022 mem_d_data_rd_o, mem_d_error_o, mem_d_resp_tag_o are 0 in every cycle mem_d_ack_o is 0.
REQ-023 Responses always in acceptance order; no ack without a prior accept.

Reset
REQ-024 While rst_i high: queue emptied, FSM IDLE, all outputs 0 including mem_d_accept_o.
REQ-025 Reset mid-operation drops queued requests with no ack; pending writes in queue not performed; RAM contents not reset.
REQ-026 First cycle after rst_i deasserts: mem_d_accept_o = 1.

Configuration
REQ-027 Macro DPORT_TCM_RESP_STALL_EN compiles in random wait-states: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every cycle out of reset); FSM gains state WAIT; IDLE/ISSUE -> WAIT instead of popping when LFSR[0]=1; WAIT -> ISSUE next cycle unconditionally.
REQ-028 Without the macro: no LFSR, no WAIT state, behaviour exactly REQ-014/015.

Structure
REQ-029 Package dport_tcm_pkg holds op enum (OP_READ, OP_WRITE, OP_MAINT), queue entry struct, FSM state enum, LFSR seed and taps constants.
REQ-030 Sub-module dport_tcm_fifo: parameterised synchronous FIFO (push, pop, full, empty, count) used for the request queue; RAM inferred in the top.

Verification
REQ-031 Write 0xDEADBEEF, be=4'hF, addr 0x80000010, tag 5 -> ack tag 5, error 0, data 0; then read same addr, tag 6 -> ack tag 6, data 0xDEADBEEF.
REQ-032 Write 0x000000AA, be=4'b0001 to 0x80000010, then read -> data 0xDEADBEAA.
REQ-033 Read addr 0x7FFFFFFC and 0x80010000, tags 1,2 -> two acks, error 1, data 0, tags 1 then 2.
REQ-034 Back-to-back 8 reads, tags 0..7, no stall build -> accept high every cycle, acks on 8 consecutive cycles in tag order, first ack 2 cycles after first accept.
REQ-035 STALL_EN build, 200 random requests -> accept drops when 4 queued, all tags returned in order, data matches reference model.
REQ-036 Queue 3 writes, assert rst_i one cycle before first ack -> no acks; read back shows old contents; accept=1 after release.

Source files
------------

// File: rtl/dport_tcm_pkg.sv
// Shared types and constants for the data-port TCM responder.
// The WAIT state exists only when DPORT_TCM_RESP_STALL_EN is defined.
package dport_tcm_pkg;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_MAINT
    } tcm_op_e;

    typedef struct packed {
        tcm_op_e     op;
        logic [29:0] word_addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [10:0] tag;
    } tcm_entry_t;

`ifdef DPORT_TCM_RESP_STALL_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } tcm_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE
    } tcm_state_e;
`endif

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form over bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dport_tcm_fifo.sv
// Synchronous in-order FIFO used as the request queue; DEPTH must be a power of two.
module dport_tcm_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/dport_tcm_resp.sv
// Data-port TCM responder: queued in-order requests, one single-cycle ack per request.
// Define DPORT_TCM_RESP_STALL_EN to insert LFSR-driven wait-states before each pop.
module dport_tcm_resp
    import dport_tcm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h80000000,
    parameter int unsigned SIZE_WORDS  = 16384,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_cacheable_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic [10:0] mem_d_resp_tag_o
);

    localparam int unsigned IDX_W     = $clog2(SIZE_WORDS);
    localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    logic [31:0]      ram [SIZE_WORDS];
    tcm_entry_t       req_entry;
    tcm_entry_t       head;
    tcm_state_e       state_q;
    logic             req_valid;
    logic             push;
    logic             pop;
    logic             stall;
    logic             queue_full;
    logic             queue_empty;
    logic [CNT_W-1:0] queue_count;
    logic [CNT_W-1:0] count_after;
    logic             busy_next;
    logic [29:0]      word_off;
    logic             head_in_range;
    logic [IDX_W-1:0] head_idx;
    logic             ack_q;
    logic             err_q;
    logic [31:0]      data_q;
    logic [10:0]      tag_q;
    logic             unused_bits;

    assign unused_bits = ^{mem_d_cacheable_i, mem_d_addr_i[1:0]};

    assign req_valid = mem_d_rd_i || (mem_d_wr_i != '0) || mem_d_invalidate_i
                       || mem_d_writeback_i || mem_d_flush_i;
    assign push      = req_valid && mem_d_accept_o;

    always_comb begin
        req_entry.op        = (mem_d_wr_i != '0) ? OP_WRITE : (mem_d_rd_i ? OP_READ : OP_MAINT);
        req_entry.word_addr = mem_d_addr_i[31:2];
        req_entry.data      = mem_d_data_wr_i;
        req_entry.be        = mem_d_wr_i;
        req_entry.tag       = mem_d_req_tag_i;
    end

    dport_tcm_fifo #(
        .WIDTH ($bits(tcm_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .pop     (pop),
        .wr_data (req_entry),
        .rd_data (head),
        .full    (queue_full),
        .empty   (queue_empty),
        .count   (queue_count)
    );

`ifdef DPORT_TCM_RESP_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            lfsr_q <= LFSR_SEED;
        else
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign mem_d_accept_o = !queue_full && !rst_i;
    assign pop            = (state_q == ST_ISSUE) && !stall && !queue_empty;
    assign count_after    = queue_count + CNT_W'(push) - CNT_W'(pop);
    assign busy_next      = (count_after != '0);

    // State is decided from the post-edge occupancy, so ISSUE is already
    // active in the cycle after the first push: accept-to-ack is two cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (busy_next)
`ifdef DPORT_TCM_RESP_STALL_EN
                        state_q <= stall ? ST_WAIT : ST_ISSUE;
`else
                        state_q <= ST_ISSUE;
`endif
                end
                ST_ISSUE: begin
`ifdef DPORT_TCM_RESP_STALL_EN
                    if (stall)
                        state_q <= ST_WAIT;
                    else
`endif
                    if (!busy_next)
                        state_q <= ST_IDLE;
                end
`ifdef DPORT_TCM_RESP_STALL_EN
                ST_WAIT: state_q <= ST_ISSUE;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign word_off      = head.word_addr - BASE_WORD;
    assign head_in_range = (head.word_addr >= BASE_WORD) && ({2'b00, word_off} < SIZE_WORDS);
    assign head_idx      = word_off[IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        if (pop && !rst_i && head.op == OP_WRITE && head_in_range) begin
            for (int unsigned b = 0; b < 4; b++)
                if (head.be[b])
                    ram[head_idx][8*b +: 8] <= head.data[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            ack_q  <= pop;
            err_q  <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
            if (pop) begin
                tag_q <= head.tag;
                if (head.op != OP_MAINT && !head_in_range)
                    err_q <= 1'b1;
                else if (head.op == OP_READ)
                    data_q <= ram[head_idx];
            end
        end
    end

    // Response registers can still hold a pop from before reset rose.
    assign mem_d_ack_o      = ack_q && !rst_i;
    assign mem_d_error_o    = err_q && !rst_i;
    assign mem_d_data_rd_o  = rst_i ? '0 : data_q;
    assign mem_d_resp_tag_o = rst_i ? '0 : tag_q;

endmodule

// File: tb/tb_dport_tcm_resp.sv
// Directed self-checking bench for dport_tcm_resp, plus a mixed random run against a word model.
module tb_dport_tcm_resp;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] addr, wdata;
    logic        rd;
    logic [3:0]  wr;
    logic [10:0] req_tag;
    logic        cacheable, inval, wb, flush;
    logic        accept, ack, err;
    logic [31:0] rdata;
    logic [10:0] resp_tag;

    always #5 clk = ~clk;

    dport_tcm_resp dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .mem_d_addr_i       (addr),
        .mem_d_data_wr_i    (wdata),
        .mem_d_rd_i         (rd),
        .mem_d_wr_i         (wr),
        .mem_d_req_tag_i    (req_tag),
        .mem_d_cacheable_i  (cacheable),
        .mem_d_invalidate_i (inval),
        .mem_d_writeback_i  (wb),
        .mem_d_flush_i      (flush),
        .mem_d_accept_o     (accept),
        .mem_d_ack_o        (ack),
        .mem_d_error_o      (err),
        .mem_d_data_rd_o    (rdata),
        .mem_d_resp_tag_o   (resp_tag)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned n_acc = 0;
    int unsigned n_ack = 0;
    logic        saw_full = 1'b0;

    logic [10:0]  got_tag [$];
    logic [31:0]  got_data [$];
    logic         got_err [$];
    int unsigned  got_cyc [$];
    int unsigned  acc_cyc [$];

    logic [10:0]  exp_tag [$];
    logic [31:0]  exp_data [$];
    logic         exp_err [$];

    logic [31:0]  model [16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!accept && !rst_i)
            saw_full = 1'b1;
        if (ack) begin
            check("ack_has_req", 64'(n_ack < n_acc), 64'd1);
            n_ack++;
            got_tag.push_back(resp_tag);
            got_data.push_back(rdata);
            got_err.push_back(err);
            got_cyc.push_back(cyc);
        end else begin
            check("idle_zero", 64'({err, rdata, resp_tag}), 64'd0);
        end
    endtask

    task automatic idle_inputs();
        rd = 1'b0; wr = '0; flush = 1'b0; inval = 1'b0; wb = 1'b0;
    endtask

    // m: 0 none, 1 flush, 2 invalidate, 3 writeback
    task automatic send(input logic r, input logic [3:0] w, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] d, input logic [10:0] t);
        int unsigned n;
        n = 0;
        rd = r; wr = w; addr = a; wdata = d; req_tag = t;
        flush = (m == 2'd1); inval = (m == 2'd2); wb = (m == 2'd3);
        cacheable = 1'($urandom_range(0, 1));
        while (!accept && n < 100) begin
            tick();
            n++;
        end
        if (!accept) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            acc_cyc.push_back(cyc);
            n_acc++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic expect_resp(input string nm, input logic [10:0] t, input logic [31:0] d,
                               input logic e, output int unsigned c);
        int unsigned n;
        n = 0;
        c = 0;
        while (got_tag.size() == 0 && n < 200) begin
            tick();
            n++;
        end
        if (got_tag.size() == 0) begin
            check({nm, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({nm, "_tag"}, 64'(got_tag.pop_front()), 64'(t));
            check({nm, "_data"}, 64'(got_data.pop_front()), 64'(d));
            check({nm, "_err"}, 64'(got_err.pop_front()), 64'(e));
            c = got_cyc.pop_front();
        end
    endtask

    task automatic drain(input string nm);
        int unsigned c;
        while (exp_tag.size() != 0)
            expect_resp(nm, exp_tag.pop_front(), exp_data.pop_front(), exp_err.pop_front(), c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned c, first_ack, k, w;
    logic [31:0] a, d;
    logic [3:0]  be;

    initial begin
        rst_i = 1'b1;
        addr = '0; wdata = '0; req_tag = '0; cacheable = 1'b0;
        idle_inputs();
        repeat (3) tick();
        check("rst_accept", 64'(accept), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        rst_i = 1'b0;
        #1;
        check("accept_after_rst", 64'(accept), 64'd1);

        // full-word write then read back
        send(1'b0, 4'hF, 2'd0, 32'h80000010, 32'hDEADBEEF, 11'd5);
        expect_resp("wr5", 11'd5, 32'h0, 1'b0, c);
        send(1'b1, 4'h0, 2'd0, 32'h80000010, 32'h0, 11'd6);
        expect_resp("rd6", 11'd6, 32'hDEADBEEF, 1'b0, c);

        // byte-lane writes
        send(1'b0, 4'b0001, 2'd0, 32'h80000010, 32'h000000AA, 11'd7);
        expect_resp("wr7", 11'd7, 32'h0, 1'b0, c);
        send(1'b1, 4'h0, 2'd0, 32'h80000010, 32'h0, 11'd8);
        expect_resp("rd8_be0", 11'd8, 32'hDEADBEAA, 1'b0, c);
        send(1'b0, 4'b1010, 2'd0, 32'h80000010, 32'h11223344, 11'd9);
        send(1'b1, 4'h0, 2'd0, 32'h80000010, 32'h0, 11'd19);
        expect_resp("wr9", 11'd9, 32'h0, 1'b0, c);
        expect_resp("rd19_be31", 11'd19, 32'h11AD33AA, 1'b0, c);

        // out-of-range reads on both sides of the window
        send(1'b1, 4'h0, 2'd0, 32'h7FFFFFFC, 32'h0, 11'd1);
        send(1'b1, 4'h0, 2'd0, 32'h80010000, 32'h0, 11'd2);
        expect_resp("oor_lo", 11'd1, 32'h0, 1'b1, c);
        expect_resp("oor_hi", 11'd2, 32'h0, 1'b1, c);

        // last word in range, and an out-of-range write that must not alias word 0
        send(1'b0, 4'hF, 2'd0, 32'h8000FFFC, 32'hCAFEF00D, 11'd3);
        send(1'b1, 4'h0, 2'd0, 32'h8000FFFC, 32'h0, 11'd4);
        send(1'b0, 4'hF, 2'd0, 32'h80000000, 32'h01020304, 11'd11);
        send(1'b0, 4'hF, 2'd0, 32'h80010000, 32'hFFFFFFFF, 11'd12);
        send(1'b1, 4'h0, 2'd0, 32'h80000000, 32'h0, 11'd13);
        expect_resp("last_wr", 11'd3, 32'h0, 1'b0, c);
        expect_resp("last_rd", 11'd4, 32'hCAFEF00D, 1'b0, c);
        expect_resp("w0_wr", 11'd11, 32'h0, 1'b0, c);
        expect_resp("oor_wr", 11'd12, 32'h0, 1'b1, c);
        expect_resp("w0_rd", 11'd13, 32'h01020304, 1'b0, c);

        // maintenance ops: no error even out of range, no RAM effect; addr[1:0] ignored
        send(1'b0, 4'h0, 2'd1, 32'h80000010, 32'h12345678, 11'd14);
        send(1'b0, 4'h0, 2'd2, 32'h00000000, 32'h12345678, 11'd15);
        send(1'b0, 4'h0, 2'd3, 32'h80000010, 32'h12345678, 11'd16);
        send(1'b1, 4'h0, 2'd0, 32'h80000013, 32'h0, 11'd17);
        expect_resp("flush", 11'd14, 32'h0, 1'b0, c);
        expect_resp("inval", 11'd15, 32'h0, 1'b0, c);
        expect_resp("wback", 11'd16, 32'h0, 1'b0, c);
        expect_resp("rd_unaligned", 11'd17, 32'h11AD33AA, 1'b0, c);

        // back-to-back reads: one accept and one ack per cycle
        for (int unsigned i = 0; i < 8; i++)
            send(1'b0, 4'hF, 2'd0, 32'h80000100 + 4 * i, 32'hA5000000 | i, 11'(100 + i));
        for (int unsigned i = 0; i < 8; i++)
            expect_resp("b2b_wr", 11'(100 + i), 32'h0, 1'b0, c);
        acc_cyc.delete();
        for (int unsigned i = 0; i < 8; i++)
            send(1'b1, 4'h0, 2'd0, 32'h80000100 + 4 * i, 32'h0, 11'(i));
        first_ack = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            expect_resp("b2b_rd", 11'(i), 32'hA5000000 | i, 1'b0, c);
            if (i == 0)
                first_ack = c;
`ifndef DPORT_TCM_RESP_STALL_EN
            else
                check("b2b_ack_cycle", 64'(c), 64'(first_ack + i));
            check("b2b_acc_cycle", 64'(acc_cyc[i]), 64'(acc_cyc[0] + i));
`endif
        end
`ifndef DPORT_TCM_RESP_STALL_EN
        check("b2b_latency", 64'(first_ack), 64'(acc_cyc[0] + 2));
`endif

        // reset while a write is queued: it is dropped and never acked
        send(1'b0, 4'hF, 2'd0, 32'h80000300, 32'h00001111, 11'd40);
        send(1'b0, 4'hF, 2'd0, 32'h80000304, 32'h00002222, 11'd41);
        send(1'b0, 4'hF, 2'd0, 32'h80000308, 32'h00003333, 11'd42);
        for (int unsigned i = 0; i < 3; i++)
            expect_resp("pre_rst_wr", 11'(40 + i), 32'h0, 1'b0, c);
        send(1'b0, 4'hF, 2'd0, 32'h80000300, 32'hBAD00001, 11'd50);
        rst_i = 1'b1;
        rd = 1'b0; wr = 4'hF; addr = 32'h80000304; wdata = 32'hBAD00002; req_tag = 11'd51;
        #1;
        check("rst_mid_accept", 64'(accept), 64'd0);
        tick();
        tick();
        rst_i = 1'b0;
        idle_inputs();
        #1;
        check("rst_mid_release_accept", 64'(accept), 64'd1);
        n_acc = n_ack;
        repeat (10) tick();
        check("rst_no_ack", 64'(got_tag.size()), 64'd0);
        send(1'b1, 4'h0, 2'd0, 32'h80000300, 32'h0, 11'd60);
        send(1'b1, 4'h0, 2'd0, 32'h80000304, 32'h0, 11'd61);
        send(1'b1, 4'h0, 2'd0, 32'h80000308, 32'h0, 11'd62);
        expect_resp("rst_old0", 11'd60, 32'h00001111, 1'b0, c);
        expect_resp("rst_old1", 11'd61, 32'h00002222, 1'b0, c);
        expect_resp("rst_old2", 11'd62, 32'h00003333, 1'b0, c);

        // mixed random traffic against a 16-word model
        for (int unsigned i = 0; i < 16; i++) begin
            d = $urandom();
            model[i] = d;
            send(1'b0, 4'hF, 2'd0, 32'h80000200 + 4 * i, d, 11'(300 + i));
            exp_tag.push_back(11'(300 + i)); exp_data.push_back(32'h0); exp_err.push_back(1'b0);
        end
        for (int unsigned i = 0; i < 200; i++) begin
            k  = $urandom_range(0, 4);
            w  = $urandom_range(0, 15);
            a  = 32'h80000200 + 4 * w;
            d  = $urandom();
            be = 4'($urandom_range(1, 15));
            exp_tag.push_back(11'(1000 + i));
            case (k)
                0, 1: begin
                    send(1'b1, 4'h0, 2'd0, a, d, 11'(1000 + i));
                    exp_data.push_back(model[w]); exp_err.push_back(1'b0);
                end
                2: begin
                    send(1'b0, be, 2'd0, a, d, 11'(1000 + i));
                    for (int unsigned b = 0; b < 4; b++)
                        if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
                    exp_data.push_back(32'h0); exp_err.push_back(1'b0);
                end
                3: begin
                    send(1'b0, 4'h0, 2'($urandom_range(1, 3)), a, d, 11'(1000 + i));
                    exp_data.push_back(32'h0); exp_err.push_back(1'b0);
                end
                default: begin
                    a = (w[0]) ? 32'h7FFFFFFC - 4 * w : 32'h80010000 + 4 * w;
                    if (w[1]) send(1'b1, 4'h0, 2'd0, a, d, 11'(1000 + i));
                    else      send(1'b0, be, 2'd0, a, d, 11'(1000 + i));
                    exp_data.push_back(32'h0); exp_err.push_back(1'b1);
                end
            endcase
        end
        drain("rnd");
        for (int unsigned i = 0; i < 16; i++)
            send(1'b1, 4'h0, 2'd0, 32'h80000200 + 4 * i, 32'h0, 11'(1500 + i));
        for (int unsigned i = 0; i < 16; i++)
            expect_resp("rnd_final", 11'(1500 + i), model[i], 1'b0, c);
`ifdef DPORT_TCM_RESP_STALL_EN
        check("stall_queue_filled", 64'(saw_full), 64'd1);
`endif
        repeat (5) tick();
        check("no_extra_acks", 64'(got_tag.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
